pipe_stall_ctrl: RTL

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/pipe_stall_ctrl_if.sv | 33 +++
 rtl/sat_counter.sv | 18 +
 rtl/pipe_stall_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: stall controller state encoding and multdiv timing defaults.
package cpu_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam int MD_TIMEOUT_DEF = 40;
  localparam int WAIT_W         = 6;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/multdiv handshake between the pipeline datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_stall;
  logic             branch_taken;
  logic             dx_is_mult;
  logic             dx_is_div;
  logic             md_ready;
  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             fd_flush;
  logic             dx_flush;
  logic             xm_nop;
  logic             md_ctrl_mult;
  logic             md_ctrl_div;
  logic             md_busy;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hazard_stall, branch_taken, dx_is_mult, dx_is_div, md_ready,
    input  pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop,
           md_ctrl_mult, md_ctrl_div, md_busy, md_timeout, stall_count
  );

  modport slave (
    input  hazard_stall, branch_taken, dx_is_mult, dx_is_div, md_ready,
    output pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop,
           md_ctrl_mult, md_ctrl_div, md_busy, md_timeout, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: branch flush, load-use bubble, and multdiv wait with timeout release.
module pipe_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  pipe_stall_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  logic pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop;
  logic md_ctrl_mult, md_ctrl_div, md_busy, md_timeout;

  always_comb begin
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    xm_nop       = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_busy      = 1'b0;
    md_timeout   = 1'b0;
    state_nxt    = state;
    wait_nxt     = wait_cnt;

    if (reset) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      fd_flush = 1'b1;
      dx_flush = 1'b1;
      xm_nop   = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (bus.hazard_stall) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            dx_en  = 1'b0;
            xm_nop = 1'b1;
          end else if (bus.dx_is_mult || bus.dx_is_div) begin
            // Start pulse; mult wins if the decoder flags both.
            md_ctrl_mult = bus.dx_is_mult;
            md_ctrl_div  = bus.dx_is_div && !bus.dx_is_mult;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            dx_en        = 1'b0;
            xm_nop       = 1'b1;
            state_nxt    = MD_WAIT;
            wait_nxt     = '0;
          end
        end
        MD_WAIT: begin
          if (bus.md_ready) begin
            state_nxt = RUN;
          end else if (wait_cnt == TO_LAST) begin
            md_timeout = 1'b1;
            state_nxt  = RUN;
          end else begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_nop   = 1'b1;
            md_busy  = 1'b1;
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (!pc_en),
    .count (bus.stall_count)
  );

  assign bus.pc_en        = pc_en;
  assign bus.fd_en        = fd_en;
  assign bus.dx_en        = dx_en;
  assign bus.fd_flush     = fd_flush;
  assign bus.dx_flush     = dx_flush;
  assign bus.xm_nop       = xm_nop;
  assign bus.md_ctrl_mult = md_ctrl_mult;
  assign bus.md_ctrl_div  = md_ctrl_div;
  assign bus.md_busy      = md_busy;
  assign bus.md_timeout   = md_timeout;

endmodule
